// File: rtl/mod_onehot_pkg.sv
// Shared definitions for the one-hot modulo-N accumulator: operation codes and operand checking.
package mod_onehot_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'd0,
    OP_SUB  = 2'd1,
    OP_LOAD = 2'd2,
    OP_CLR  = 2'd3
  } op_e;

  // Widest modulus onehot_ok can check; callers zero-extend narrower vectors.
  localparam int MAX_N = 64;

  function automatic logic onehot_ok(input logic [MAX_N-1:0] vec);
    int cnt;
    cnt = 0;
    for (int i = 0; i < MAX_N; i++) begin
      cnt += int'(vec[i]);
    end
    return (cnt == 1);
  endfunction

endpackage

// File: rtl/mod_onehot_rot.sv
// Combinational one-hot modulo-N add/subtract: each result bit is an OR of AND terms over operand pairs.
module mod_onehot_rot #(
  parameter int N = 3
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] k,
  input  logic         dir,
  output logic [N-1:0] sum,
  output logic         wrap
);

  logic [N*N-1:0] add_w;
  logic [N*N-1:0] sub_w;

  for (genvar j = 0; j < N; j++) begin : g_bit
    logic [N-1:0] add_t;
    logic [N-1:0] sub_t;
    for (genvar i = 0; i < N; i++) begin : g_term
      // a=i plus k=(j-i) lands on j; a=i minus k=(i-j) lands on j
      assign add_t[i] = a[i] & k[(j - i + N) % N];
      assign sub_t[i] = a[i] & k[(i - j + N) % N];
    end
    assign sum[j] = dir ? |sub_t : |add_t;
  end

  for (genvar i = 0; i < N; i++) begin : g_wa
    for (genvar kk = 0; kk < N; kk++) begin : g_wk
      if (i + kk >= N) begin : g_addw
        assign add_w[i*N+kk] = a[i] & k[kk];
      end else begin : g_addn
        assign add_w[i*N+kk] = 1'b0;
      end
      if (kk > i) begin : g_subw
        assign sub_w[i*N+kk] = a[i] & k[kk];
      end else begin : g_subn
        assign sub_w[i*N+kk] = 1'b0;
      end
    end
  end

  assign wrap = dir ? |sub_w : |add_w;

endmodule

// File: rtl/mod_onehot_accum.sv
// One-hot modulo-N accumulator with a single registered result stage and valid/ready on both sides.
// The accumulator register doubles as OutSum, so it only moves on accept and holds during stalls.
module mod_onehot_accum
  import mod_onehot_pkg::*;
#(
  parameter int N  = 3,
  parameter int CW = 8
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          InValid,
  output logic          InReady,
  input  logic [1:0]    InOp,
  input  logic [N-1:0]  InData,
  output logic          OutValid,
  input  logic          OutReady,
  output logic [N-1:0]  OutSum,
  output logic          OutWrap,
  output logic          OutErr,
  output logic [CW-1:0] WrapCount
);

  localparam logic [N-1:0] ONEHOT_ZERO = N'(1);

  logic [N-1:0]     rot_sum;
  logic             rot_wrap;
  logic             accept;
  logic             data_ok;
  logic [MAX_N-1:0] data_ext;

  always_comb begin
    data_ext         = '0;
    data_ext[N-1:0]  = InData;
  end

  assign data_ok = onehot_ok(data_ext);
  assign InReady = !OutValid || OutReady;
  assign accept  = InValid && InReady;

  mod_onehot_rot #(.N(N)) u_rot (
    .a    (OutSum),
    .k    (InData),
    .dir  (InOp == OP_SUB),
    .sum  (rot_sum),
    .wrap (rot_wrap)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      OutSum    <= ONEHOT_ZERO;
      OutValid  <= 1'b0;
      OutWrap   <= 1'b0;
      OutErr    <= 1'b0;
      WrapCount <= '0;
    end else if (accept) begin
      OutValid <= 1'b1;
      case (InOp)
        OP_CLR: begin
          OutSum    <= ONEHOT_ZERO;
          OutWrap   <= 1'b0;
          OutErr    <= 1'b0;
          WrapCount <= '0;
        end
        OP_LOAD: begin
          OutWrap <= 1'b0;
          OutErr  <= !data_ok;
          if (data_ok) OutSum <= InData;
        end
        default: begin
          // malformed operands still yield a result so the handshake keeps moving
          OutErr  <= !data_ok;
          OutWrap <= data_ok && rot_wrap;
          if (data_ok) begin
            OutSum <= rot_sum;
            if (rot_wrap) WrapCount <= WrapCount + CW'(1);
          end
        end
      endcase
    end else if (OutReady) begin
      OutValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mod_onehot_accum.sv
// Directed bench for mod_onehot_accum: N=3, N=5 and a narrow-counter N=3 instance.
module tb_mod_onehot_accum;
  import mod_onehot_pkg::*;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;

  // N=3, CW=8
  logic       iv3 = 0, ir3, ov3, or3 = 1, w3, e3;
  logic [1:0] o3 = 0;
  logic [2:0] d3 = 0, s3;
  logic [7:0] wc3;
  // N=5, CW=8
  logic       iv5 = 0, ir5, ov5, or5 = 1, w5, e5;
  logic [1:0] o5 = 0;
  logic [4:0] d5 = 0, s5;
  logic [7:0] wc5;
  // N=3, CW=2
  logic       ivc = 0, irc, ovc, orc = 1, wc, ec;
  logic [1:0] oc = 0;
  logic [2:0] dc = 0, sc;
  logic [1:0] wcc;

  mod_onehot_accum #(.N(3), .CW(8)) dut3 (
    .Clk(Clk), .Reset(Reset), .InValid(iv3), .InReady(ir3), .InOp(o3), .InData(d3),
    .OutValid(ov3), .OutReady(or3), .OutSum(s3), .OutWrap(w3), .OutErr(e3), .WrapCount(wc3));
  mod_onehot_accum #(.N(5), .CW(8)) dut5 (
    .Clk(Clk), .Reset(Reset), .InValid(iv5), .InReady(ir5), .InOp(o5), .InData(d5),
    .OutValid(ov5), .OutReady(or5), .OutSum(s5), .OutWrap(w5), .OutErr(e5), .WrapCount(wc5));
  mod_onehot_accum #(.N(3), .CW(2)) dutc (
    .Clk(Clk), .Reset(Reset), .InValid(ivc), .InReady(irc), .InOp(oc), .InData(dc),
    .OutValid(ovc), .OutReady(orc), .OutSum(sc), .OutWrap(wc), .OutErr(ec), .WrapCount(wcc));

  task automatic op3(input logic [1:0] op, input logic [2:0] d);
    @(negedge Clk); iv3 = 1; o3 = op; d3 = d;
    @(posedge Clk); #1; iv3 = 0;
  endtask

  task automatic op5(input logic [1:0] op, input logic [4:0] d);
    @(negedge Clk); iv5 = 1; o5 = op; d5 = d;
    @(posedge Clk); #1; iv5 = 0;
  endtask

  task automatic opc(input logic [1:0] op, input logic [2:0] d);
    @(negedge Clk); ivc = 1; oc = op; dc = d;
    @(posedge Clk); #1; ivc = 0;
  endtask

  task automatic test_reset;
    #12;
    total++; if (s3 !== 3'b001) begin bad++; $display("FAIL rst_sum got=%b exp=001", s3); end
    total++; if (ov3 !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", ov3); end
    total++; if (wc3 !== 8'd0 || w3 !== 1'b0 || e3 !== 1'b0) begin bad++; $display("FAIL rst_flags wc=%0d w=%b e=%b exp 0/0/0", wc3, w3, e3); end
    total++; if (ir3 !== 1'b1) begin bad++; $display("FAIL rst_inready got=%b exp=1", ir3); end
    total++; if (s5 !== 5'b00001) begin bad++; $display("FAIL rst_sum5 got=%b exp=00001", s5); end
    @(negedge Clk); Reset = 0;
  endtask

  task automatic test_add;
    op3(OP_ADD, 3'b100);
    total++; if (s3 !== 3'b100 || w3 !== 1'b0 || ov3 !== 1'b1) begin bad++; $display("FAIL add1 sum=%b w=%b v=%b exp 100/0/1", s3, w3, ov3); end
    op3(OP_ADD, 3'b010);
    total++; if (s3 !== 3'b001 || w3 !== 1'b1) begin bad++; $display("FAIL add2 sum=%b w=%b exp 001/1", s3, w3); end
    total++; if (wc3 !== 8'd1) begin bad++; $display("FAIL add2_wc got=%0d exp=1", wc3); end
  endtask

  task automatic test_backpressure;
    @(negedge Clk); or3 = 1; iv3 = 0;
    @(negedge Clk);
    total++; if (ov3 !== 1'b0) begin bad++; $display("FAIL bp_drain got=%b exp=0", ov3); end
    or3 = 0; iv3 = 1; o3 = OP_ADD; d3 = 3'b010;
    @(posedge Clk); #1;
    o3 = OP_ADD; d3 = 3'b100;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      total++;
      if (ir3 !== 1'b0 || ov3 !== 1'b1 || s3 !== 3'b010 || w3 !== 1'b0 || wc3 !== 8'd1) begin
        bad++; $display("FAIL bp_hold%0d rdy=%b v=%b sum=%b w=%b wc=%0d exp 0/1/010/0/1", i, ir3, ov3, s3, w3, wc3);
      end
    end
    @(negedge Clk); or3 = 1; #1;
    total++; if (ir3 !== 1'b1) begin bad++; $display("FAIL bp_inready got=%b exp=1", ir3); end
    @(posedge Clk); #1; iv3 = 0;
    total++; if (ov3 !== 1'b1 || s3 !== 3'b001 || w3 !== 1'b1 || wc3 !== 8'd2) begin
      bad++; $display("FAIL bp_second v=%b sum=%b w=%b wc=%0d exp 1/001/1/2", ov3, s3, w3, wc3);
    end
  endtask

  task automatic test_malformed;
    op3(OP_ADD, 3'b011);
    total++; if (e3 !== 1'b1 || s3 !== 3'b001 || wc3 !== 8'd2 || w3 !== 1'b0) begin
      bad++; $display("FAIL bad_two e=%b sum=%b wc=%0d w=%b exp 1/001/2/0", e3, s3, wc3, w3);
    end
    op3(OP_ADD, 3'b000);
    total++; if (e3 !== 1'b1 || s3 !== 3'b001 || ov3 !== 1'b1) begin bad++; $display("FAIL bad_zero e=%b sum=%b v=%b exp 1/001/1", e3, s3, ov3); end
    op3(OP_ADD, 3'b010);
    total++; if (e3 !== 1'b0 || s3 !== 3'b010 || w3 !== 1'b0) begin bad++; $display("FAIL bad_recover e=%b sum=%b w=%b exp 0/010/0", e3, s3, w3); end
  endtask

  task automatic test_sub5;
    op5(OP_LOAD, 5'b00010);
    total++; if (s5 !== 5'b00010 || w5 !== 1'b0) begin bad++; $display("FAIL load5 sum=%b w=%b exp 00010/0", s5, w5); end
    op5(OP_SUB, 5'b01000);
    total++; if (s5 !== 5'b01000 || w5 !== 1'b1 || wc5 !== 8'd1) begin bad++; $display("FAIL sub5 sum=%b w=%b wc=%0d exp 01000/1/1", s5, w5, wc5); end
    op5(OP_ADD, 5'b00001);
    total++; if (s5 !== 5'b01000 || w5 !== 1'b0 || e5 !== 1'b0) begin bad++; $display("FAIL addzero5 sum=%b w=%b e=%b exp 01000/0/0", s5, w5, e5); end
    op5(OP_SUB, 5'b00100);
    total++; if (s5 !== 5'b00010 || w5 !== 1'b0) begin bad++; $display("FAIL sub5_nowrap sum=%b w=%b exp 00010/0", s5, w5); end
  endtask

  task automatic test_wrapcount;
    logic [1:0] exp_wc [4];
    logic [2:0] exp_s [4];
    exp_wc[0] = 2'd1; exp_wc[1] = 2'd2; exp_wc[2] = 2'd3; exp_wc[3] = 2'd0;
    exp_s[0] = 3'b010; exp_s[1] = 3'b001; exp_s[2] = 3'b010; exp_s[3] = 3'b001;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) opc(OP_LOAD, 3'b100);
      opc(OP_ADD, 3'b100);
      total++; if (wcc !== exp_wc[i] || sc !== exp_s[i] || wc !== 1'b1) begin
        bad++; $display("FAIL wrap%0d wc=%0d sum=%b w=%b exp %0d/%b/1", i, wcc, sc, wc, exp_wc[i], exp_s[i]);
      end
    end
    opc(OP_LOAD, 3'b100);
    opc(OP_ADD, 3'b100);
    total++; if (wcc !== 2'd1) begin bad++; $display("FAIL wrap_pre_clr got=%0d exp=1", wcc); end
    opc(OP_CLR, 3'b111);
    total++; if (sc !== 3'b001 || wcc !== 2'd0 || wc !== 1'b0 || ec !== 1'b0) begin
      bad++; $display("FAIL clr sum=%b wc=%0d w=%b e=%b exp 001/0/0/0", sc, wcc, wc, ec);
    end
  endtask

  task automatic test_async_reset;
    @(negedge Clk); or3 = 0; iv3 = 1; o3 = OP_ADD; d3 = 3'b001;
    @(posedge Clk); #1; iv3 = 0;
    total++; if (ov3 !== 1'b1 || s3 !== 3'b010) begin bad++; $display("FAIL ar_pre v=%b sum=%b exp 1/010", ov3, s3); end
    #2; Reset = 1; #1;
    total++; if (ov3 !== 1'b0 || s3 !== 3'b001 || wc3 !== 8'd0) begin
      bad++; $display("FAIL ar_now v=%b sum=%b wc=%0d exp 0/001/0", ov3, s3, wc3);
    end
    @(negedge Clk); Reset = 0; or3 = 1;
  endtask

  initial begin
    test_reset();
    test_add();
    test_backpressure();
    test_malformed();
    test_sub5();
    test_wrapcount();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
